mem_arbiter: RTL

Shares the single backing memory between the instruction-cache and data-cache miss controllers. Each granted requester receives one 4-word line burst, either a read (I or D) or a write-back (D only). The block sits between both caches and the memory. Its `i_grant`/`d_grant` outputs feed the stall logic: a requester that is not granted keeps its pipeline stage stalled.

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing memory between the I- and D-cache
// miss controllers, granting one 4-word line burst per transaction.
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_grant,
    output logic        i_rvalid,
    output logic [1:0]  i_ridx,
    output logic [15:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [1:0]  d_widx,
    output logic        d_grant,
    output logic        d_rvalid,
    output logic [1:0]  d_ridx,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // owner_d/last_d: 1 means the data side
    logic        owner_d;
    logic        last_d;
    logic        wr_q;
    logic [12:0] line_q;
    logic [1:0]  issue_idx;

    logic [MEM_LAT-1:0]      sr_v;
    logic [MEM_LAT-1:0][1:0] sr_idx;

    logic       pick_d;
    logic       start;
    logic       accept;
    logic       wr_issue;
    logic       ret_v;
    logic [1:0] ret_idx;
    logic       unused_lsb;

    assign unused_lsb = ^{i_addr[2:0], d_addr[2:0]};

    assign start    = (state == IDLE) && (i_req || d_req);
    assign accept   = (state == ISSUE) && !mem_busy;
    assign wr_issue = (state == ISSUE) && wr_q;
    assign ret_v    = sr_v[MEM_LAT-1];
    assign ret_idx  = sr_idx[MEM_LAT-1];

    // On a tie the side that did not win last time goes next
    always_comb begin
        pick_d = 1'b0;
        unique case (1'b1)
            i_req && d_req:  pick_d = !last_d;
            d_req && !i_req: pick_d = 1'b1;
            default:         pick_d = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                if (accept && issue_idx == 2'd3)
                    state_nxt = wr_q ? DONE : DRAIN;
            end
            DRAIN: begin
                if (ret_v && ret_idx == 2'd3)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_grant   = (state != IDLE) && !owner_d;
        d_grant   = (state != IDLE) && owner_d;
        i_done    = (state == DONE) && !owner_d;
        d_done    = (state == DONE) && owner_d;
        mem_rd    = accept && !wr_q;
        mem_wr    = accept && wr_q;
        mem_addr  = '0;
        if (state == ISSUE)
            mem_addr = {line_q, issue_idx, 1'b0};
        d_widx    = wr_issue ? issue_idx : 2'd0;
        mem_wdata = wr_issue ? d_wdata : 16'h0000;
        i_rvalid  = ret_v && !owner_d;
        d_rvalid  = ret_v && owner_d;
        i_ridx    = ret_idx;
        d_ridx    = ret_idx;
        // Read data is forced low while reset is held
        i_rdata   = rst ? mem_rdata : 16'h0000;
        d_rdata   = rst ? mem_rdata : 16'h0000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            last_d    <= 1'b0;
            wr_q      <= 1'b0;
            line_q    <= '0;
            issue_idx <= 2'd0;
        end else begin
            state <= state_nxt;
            if (start) begin
                owner_d   <= pick_d;
                last_d    <= pick_d;
                wr_q      <= pick_d && d_wr;
                line_q    <= pick_d ? d_addr[15:3] : i_addr[15:3];
                issue_idx <= 2'd0;
            end else if (accept) begin
                issue_idx <= issue_idx + 2'd1;
            end
        end
    end

    // Return tracker: one stage per cycle of memory latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_v   <= '0;
            sr_idx <= '0;
        end else begin
            sr_v[0]   <= mem_rd;
            sr_idx[0] <= mem_rd ? issue_idx : 2'd0;
            for (int k = 1; k < MEM_LAT; k++) begin
                sr_v[k]   <= sr_v[k-1];
                sr_idx[k] <= sr_idx[k-1];
            end
        end
    end

endmodule
